// File: rtl/id_ex_stage_if.sv
// Bundle of Decode-side inputs, write-back bypass inputs and Execute-side
// outputs of the ID/EX pipeline register. The stage is the slave; whoever
// drives Decode/Write-back and observes Execute is the master.
interface id_ex_stage_if #(
  parameter int CTRL_W = 16,
  parameter int CNT_W  = 32
) ();

  // Decode instruction
  logic              id_valid;
  logic [31:0]       id_pc;
  logic [4:0]        id_rs1;
  logic [4:0]        id_rs2;
  logic [4:0]        id_rd;
  logic [31:0]       id_rd1;
  logic [31:0]       id_rd2;
  logic              id_uses_rs1;
  logic              id_uses_rs2;
  logic [31:0]       id_imm;
  logic [CTRL_W-1:0] id_ctrl;
  logic              id_reg_we;
  logic              id_mem_read;

  // Write-back port of the register file
  logic              wb_we;
  logic [4:0]        wb_wa;
  logic [31:0]       wb_wd;

  // Pipeline control
  logic              ex_ready;
  logic              flush;
  logic              id_stall;

  // Execute slot
  logic              ex_valid;
  logic [31:0]       ex_pc;
  logic [31:0]       ex_imm;
  logic [4:0]        ex_rs1;
  logic [4:0]        ex_rs2;
  logic [4:0]        ex_rd;
  logic [31:0]       ex_op1;
  logic [31:0]       ex_op2;
  logic [CTRL_W-1:0] ex_ctrl;
  logic              ex_reg_we;
  logic              ex_mem_read;

  // Event counters
  logic [CNT_W-1:0]  hazard_cnt;
  logic [CNT_W-1:0]  flush_cnt;

  modport master (
    output id_valid, id_pc, id_rs1, id_rs2, id_rd, id_rd1, id_rd2,
           id_uses_rs1, id_uses_rs2, id_imm, id_ctrl, id_reg_we, id_mem_read,
           wb_we, wb_wa, wb_wd, ex_ready, flush,
    input  id_stall, ex_valid, ex_pc, ex_imm, ex_rs1, ex_rs2, ex_rd,
           ex_op1, ex_op2, ex_ctrl, ex_reg_we, ex_mem_read,
           hazard_cnt, flush_cnt
  );

  modport slave (
    input  id_valid, id_pc, id_rs1, id_rs2, id_rd, id_rd1, id_rd2,
           id_uses_rs1, id_uses_rs2, id_imm, id_ctrl, id_reg_we, id_mem_read,
           wb_we, wb_wa, wb_wd, ex_ready, flush,
    output id_stall, ex_valid, ex_pc, ex_imm, ex_rs1, ex_rs2, ex_rd,
           ex_op1, ex_op2, ex_ctrl, ex_reg_we, ex_mem_read,
           hazard_cnt, flush_cnt
  );

endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with write-back bypass, load-use bubble insertion,
// back-pressure hold, branch flush and saturating hazard/flush counters.
module id_ex_stage #(
  parameter int CTRL_W = 16,
  parameter int CNT_W  = 32
) (
  input  logic         clk,
  input  logic         rst,
  id_ex_stage_if.slave bus
);

  localparam logic [CNT_W-1:0] CntMax = '1;

  logic [31:0]       op1N, op2N;
  logic              hold, hazard;

  logic              exValid_q,   exValid_d;
  logic [31:0]       exPc_q,      exPc_d;
  logic [31:0]       exImm_q,     exImm_d;
  logic [4:0]        exRs1_q,     exRs1_d;
  logic [4:0]        exRs2_q,     exRs2_d;
  logic [4:0]        exRd_q,      exRd_d;
  logic [31:0]       exOp1_q,     exOp1_d;
  logic [31:0]       exOp2_q,     exOp2_d;
  logic [CTRL_W-1:0] exCtrl_q,    exCtrl_d;
  logic              exRegWe_q,   exRegWe_d;
  logic              exMemRead_q, exMemRead_d;
  logic [CNT_W-1:0]  hazardCnt_q, hazardCnt_d;
  logic [CNT_W-1:0]  flushCnt_q,  flushCnt_d;

  // Operand bypass: x0 reads as zero, a same-cycle write-back wins over the stale register-file read
  always_comb begin
    op1N = bus.id_rd1;
    op2N = bus.id_rd2;
    if (bus.id_rs1 == 5'd0) begin
      op1N = 32'd0;
    end else if (bus.wb_we && (bus.wb_wa != 5'd0) && (bus.wb_wa == bus.id_rs1)) begin
      op1N = bus.wb_wd;
    end
    if (bus.id_rs2 == 5'd0) begin
      op2N = 32'd0;
    end else if (bus.wb_we && (bus.wb_wa != 5'd0) && (bus.wb_wa == bus.id_rs2)) begin
      op2N = bus.wb_wd;
    end
  end

  // Back-pressure and load-use detection; a load targeting x0 never stalls
  always_comb begin
    hold   = exValid_q && !bus.ex_ready;
    hazard = bus.id_valid && exValid_q && exMemRead_q && (exRd_q != 5'd0) &&
             ((bus.id_uses_rs1 && (bus.id_rs1 == exRd_q)) ||
              (bus.id_uses_rs2 && (bus.id_rs2 == exRd_q)));
  end

  assign bus.id_stall = !rst && !bus.flush && (hold || hazard);

  // Next-state selection in priority order: flush, hold, bubble, load
  always_comb begin
    exValid_d   = exValid_q;
    exPc_d      = exPc_q;
    exImm_d     = exImm_q;
    exRs1_d     = exRs1_q;
    exRs2_d     = exRs2_q;
    exRd_d      = exRd_q;
    exOp1_d     = exOp1_q;
    exOp2_d     = exOp2_q;
    exCtrl_d    = exCtrl_q;
    exRegWe_d   = exRegWe_q;
    exMemRead_d = exMemRead_q;
    hazardCnt_d = hazardCnt_q;
    flushCnt_d  = flushCnt_q;
    if (bus.flush) begin
      exValid_d   = 1'b0;
      exRegWe_d   = 1'b0;
      exMemRead_d = 1'b0;
      exCtrl_d    = '0;
      if (flushCnt_q != CntMax) flushCnt_d = flushCnt_q + CNT_W'(1);
    end else if (hold) begin
      exValid_d = exValid_q;
    end else if (hazard) begin
      exValid_d   = 1'b0;
      exRegWe_d   = 1'b0;
      exMemRead_d = 1'b0;
      exCtrl_d    = '0;
      if (hazardCnt_q != CntMax) hazardCnt_d = hazardCnt_q + CNT_W'(1);
    end else begin
      exValid_d   = bus.id_valid;
      exPc_d      = bus.id_pc;
      exImm_d     = bus.id_imm;
      exRs1_d     = bus.id_rs1;
      exRs2_d     = bus.id_rs2;
      exRd_d      = bus.id_rd;
      exOp1_d     = op1N;
      exOp2_d     = op2N;
      exCtrl_d    = bus.id_valid ? bus.id_ctrl : '0;
      exRegWe_d   = bus.id_reg_we && bus.id_valid;
      exMemRead_d = bus.id_mem_read && bus.id_valid;
    end
  end

  // Pipeline register with synchronous clear
  always_ff @(posedge clk) begin
    if (rst) begin
      exValid_q   <= 1'b0;
      exPc_q      <= '0;
      exImm_q     <= '0;
      exRs1_q     <= '0;
      exRs2_q     <= '0;
      exRd_q      <= '0;
      exOp1_q     <= '0;
      exOp2_q     <= '0;
      exCtrl_q    <= '0;
      exRegWe_q   <= 1'b0;
      exMemRead_q <= 1'b0;
      hazardCnt_q <= '0;
      flushCnt_q  <= '0;
    end else begin
      exValid_q   <= exValid_d;
      exPc_q      <= exPc_d;
      exImm_q     <= exImm_d;
      exRs1_q     <= exRs1_d;
      exRs2_q     <= exRs2_d;
      exRd_q      <= exRd_d;
      exOp1_q     <= exOp1_d;
      exOp2_q     <= exOp2_d;
      exCtrl_q    <= exCtrl_d;
      exRegWe_q   <= exRegWe_d;
      exMemRead_q <= exMemRead_d;
      hazardCnt_q <= hazardCnt_d;
      flushCnt_q  <= flushCnt_d;
    end
  end

  assign bus.ex_valid    = exValid_q;
  assign bus.ex_pc       = exPc_q;
  assign bus.ex_imm      = exImm_q;
  assign bus.ex_rs1      = exRs1_q;
  assign bus.ex_rs2      = exRs2_q;
  assign bus.ex_rd       = exRd_q;
  assign bus.ex_op1      = exOp1_q;
  assign bus.ex_op2      = exOp2_q;
  assign bus.ex_ctrl     = exCtrl_q;
  assign bus.ex_reg_we   = exRegWe_q;
  assign bus.ex_mem_read = exMemRead_q;
  assign bus.hazard_cnt  = hazardCnt_q;
  assign bus.flush_cnt   = flushCnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage with a cycle-level reference model of the
// Execute slot and literal expectations at the interesting points.
module tb_id_ex_stage;

  localparam int CTRL_W = 16;
  localparam int CNT_W  = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  id_ex_stage_if #(.CTRL_W(CTRL_W), .CNT_W(CNT_W)) bus ();

  id_ex_stage #(.CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock, period 10
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state of the Execute slot
  bit          modelReady = 0;
  bit          mValid, mRegWe, mMemRead;
  logic [31:0] mPc, mImm, mOp1, mOp2;
  logic [4:0]  mRs1, mRs2, mRd;
  logic [15:0] mCtrl;
  int          mHazCnt, mFlushCnt;

  function automatic logic [31:0] bypassed(input logic [4:0] rs, input logic [31:0] rfData);
    if (rs == 0) return 32'd0;
    if (bus.wb_we && bus.wb_wa == rs) return bus.wb_wd;
    return rfData;
  endfunction

  function automatic bit modelHazard();
    bit needs = (bus.id_uses_rs1 && bus.id_rs1 == mRd) || (bus.id_uses_rs2 && bus.id_rs2 == mRd);
    return bus.id_valid && mValid && mMemRead && mRd != 0 && needs;
  endfunction

  function automatic bit modelStall();
    return !rst && !bus.flush && ((mValid && !bus.ex_ready) || modelHazard());
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Model advances on each rising edge from the inputs presented before it
  always @(posedge clk) begin
    if (rst) begin
      {mValid, mRegWe, mMemRead} = '0;
      {mPc, mImm, mOp1, mOp2} = '0;
      {mRs1, mRs2, mRd} = '0;
      mCtrl = '0;
      mHazCnt = 0;
      mFlushCnt = 0;
      modelReady = 1;
    end else if (modelReady) begin
      if (bus.flush) begin
        {mValid, mRegWe, mMemRead} = '0;
        mCtrl = '0;
        if (mFlushCnt < CNT_MAX) mFlushCnt++;
      end else if (mValid && !bus.ex_ready) begin
        // Execute is stalled, nothing moves
      end else if (modelHazard()) begin
        {mValid, mRegWe, mMemRead} = '0;
        mCtrl = '0;
        if (mHazCnt < CNT_MAX) mHazCnt++;
      end else begin
        mValid   = bus.id_valid;
        mPc      = bus.id_pc;
        mImm     = bus.id_imm;
        mRs1     = bus.id_rs1;
        mRs2     = bus.id_rs2;
        mRd      = bus.id_rd;
        mOp1     = bypassed(bus.id_rs1, bus.id_rd1);
        mOp2     = bypassed(bus.id_rs2, bus.id_rd2);
        mCtrl    = bus.id_valid ? bus.id_ctrl : 16'd0;
        mRegWe   = bus.id_valid && bus.id_reg_we;
        mMemRead = bus.id_valid && bus.id_mem_read;
      end
    end
  end

  // Every falling edge, all outputs are compared against the model
  always @(negedge clk) begin
    if (modelReady) begin
      checkOutput("m.id_stall",    bus.id_stall,    modelStall());
      checkOutput("m.ex_valid",    bus.ex_valid,    mValid);
      checkOutput("m.ex_pc",       bus.ex_pc,       mPc);
      checkOutput("m.ex_imm",      bus.ex_imm,      mImm);
      checkOutput("m.ex_rs1",      bus.ex_rs1,      mRs1);
      checkOutput("m.ex_rs2",      bus.ex_rs2,      mRs2);
      checkOutput("m.ex_rd",       bus.ex_rd,       mRd);
      checkOutput("m.ex_op1",      bus.ex_op1,      mOp1);
      checkOutput("m.ex_op2",      bus.ex_op2,      mOp2);
      checkOutput("m.ex_ctrl",     bus.ex_ctrl,     mCtrl);
      checkOutput("m.ex_reg_we",   bus.ex_reg_we,   mRegWe);
      checkOutput("m.ex_mem_read", bus.ex_mem_read, mMemRead);
      checkOutput("m.hazard_cnt",  bus.hazard_cnt,  mHazCnt);
      checkOutput("m.flush_cnt",   bus.flush_cnt,   mFlushCnt);
    end
  end

  // Present a Decode instruction
  task automatic applyStimulus(input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [4:0] rd, input logic [31:0] rd1, input logic [31:0] rd2,
                               input bit u1, input bit u2, input bit isLoad);
    bus.id_valid    = 1'b1;
    bus.id_pc       = pc;
    bus.id_rs1      = rs1;
    bus.id_rs2      = rs2;
    bus.id_rd       = rd;
    bus.id_rd1      = rd1;
    bus.id_rd2      = rd2;
    bus.id_uses_rs1 = u1;
    bus.id_uses_rs2 = u2;
    bus.id_imm      = pc ^ 32'h0000_0F0F;
    bus.id_ctrl     = pc[15:0] | 16'h8001;
    bus.id_reg_we   = 1'b1;
    bus.id_mem_read = isLoad;
  endtask

  task automatic stepClock();
    @(posedge clk);
    #1;
  endtask

  // Directed sequence
  initial begin
    rst = 1'b1;
    bus.wb_we = 1'b0; bus.wb_wa = '0; bus.wb_wd = '0;
    bus.ex_ready = 1'b1; bus.flush = 1'b0;
    applyStimulus(32'h80, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 1, 1, 1);

    // Reset with a valid instruction waiting
    stepClock(); stepClock();
    checkOutput("rst.ex_valid",    bus.ex_valid,    0);
    checkOutput("rst.ex_reg_we",   bus.ex_reg_we,   0);
    checkOutput("rst.ex_mem_read", bus.ex_mem_read, 0);
    checkOutput("rst.hazard_cnt",  bus.hazard_cnt,  0);
    checkOutput("rst.flush_cnt",   bus.flush_cnt,   0);
    checkOutput("rst.id_stall",    bus.id_stall,    0);
    rst = 1'b0;

    // Plain pass-through
    applyStimulus(32'h100, 5'd5, 5'd6, 5'd7, 32'h11, 32'h22, 1, 1, 0);
    bus.id_imm = 32'hFFFF_FFF0;
    stepClock();
    checkOutput("pass.ex_valid", bus.ex_valid, 1);
    checkOutput("pass.ex_op1",   bus.ex_op1,   32'h11);
    checkOutput("pass.ex_op2",   bus.ex_op2,   32'h22);
    checkOutput("pass.ex_imm",   bus.ex_imm,   32'hFFFF_FFF0);

    // Bypass from write-back
    applyStimulus(32'h104, 5'd7, 5'd6, 5'd8, 32'hAAAA, 32'h22, 1, 1, 0);
    bus.wb_we = 1'b1; bus.wb_wa = 5'd7; bus.wb_wd = 32'h1234;
    stepClock();
    checkOutput("byp.hit", bus.ex_op1, 32'h1234);
    applyStimulus(32'h108, 5'd0, 5'd6, 5'd8, 32'hAAAA, 32'h22, 1, 1, 0);
    bus.wb_wa = 5'd0; bus.wb_wd = 32'h55;
    stepClock();
    checkOutput("byp.x0", bus.ex_op1, 32'h0);
    applyStimulus(32'h10C, 5'd7, 5'd6, 5'd8, 32'hAAAA, 32'h22, 1, 1, 0);
    bus.wb_we = 1'b0; bus.wb_wa = 5'd7; bus.wb_wd = 32'h1234;
    stepClock();
    checkOutput("byp.nowe", bus.ex_op1, 32'hAAAA);

    // Load-use: one bubble, then the consumer enters Execute
    applyStimulus(32'h200, 5'd1, 5'd0, 5'd3, 32'h0, 32'h0, 1, 0, 1);
    stepClock();
    applyStimulus(32'h204, 5'd3, 5'd4, 5'd5, 32'h0, 32'h0, 1, 1, 0);
    #1 checkOutput("lu.stall", bus.id_stall, 1);
    stepClock();
    checkOutput("lu.bubble",     bus.ex_valid,   0);
    checkOutput("lu.hazard_cnt", bus.hazard_cnt, 1);
    checkOutput("lu.stall_off",  bus.id_stall,   0);
    stepClock();
    checkOutput("lu.valid", bus.ex_valid, 1);
    checkOutput("lu.pc",    bus.ex_pc,    32'h204);
    applyStimulus(32'h300, 5'd1, 5'd0, 5'd3, 32'h0, 32'h0, 1, 0, 1);
    stepClock();
    applyStimulus(32'h304, 5'd3, 5'd4, 5'd5, 32'h0, 32'h0, 0, 1, 0);
    #1 checkOutput("nolu.stall", bus.id_stall, 0);
    stepClock();
    checkOutput("nolu.pc",    bus.ex_pc,      32'h304);
    checkOutput("nolu.count", bus.hazard_cnt, 1);

    // Back-pressure for three cycles, then release
    bus.ex_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(32'h400 + 32'(4 * i), 5'd9, 5'd10, 5'd11, 32'h9, 32'hA, 1, 1, 0);
      #1 checkOutput("bp.stall", bus.id_stall, 1);
      stepClock();
      checkOutput("bp.pc", bus.ex_pc, 32'h304);
    end
    bus.ex_ready = 1'b1;
    stepClock();
    checkOutput("bp.release", bus.ex_pc, 32'h408);

    // Flush coinciding with a load-use hazard
    applyStimulus(32'h500, 5'd1, 5'd0, 5'd3, 32'h0, 32'h0, 1, 0, 1);
    stepClock();
    applyStimulus(32'h504, 5'd3, 5'd4, 5'd5, 32'h0, 32'h0, 1, 1, 0);
    bus.flush = 1'b1;
    #1 checkOutput("fl.stall", bus.id_stall, 0);
    stepClock();
    bus.flush = 1'b0;
    checkOutput("fl.valid",      bus.ex_valid,   0);
    checkOutput("fl.flush_cnt",  bus.flush_cnt,  1);
    checkOutput("fl.hazard_cnt", bus.hazard_cnt, 1);

    // Self-dependent load alternates load/bubble; count must stick at max
    applyStimulus(32'h600, 5'd3, 5'd0, 5'd3, 32'h0, 32'h0, 1, 0, 1);
    for (int i = 0; i < 40; i++) stepClock();
    checkOutput("sat.hazard_cnt", bus.hazard_cnt, 15);

    bus.id_valid = 1'b0;
    stepClock(); stepClock();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Guard against a stuck simulation
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Pipeline register between Decode and Execute.
- Captures the decoded instruction and the two register-file read operands.
- Applies write-back-to-decode bypass, because register-file writes land at the clock edge while reads are combinational.
- Detects load-use hazards and inserts bubbles, honours downstream back-pressure and branch flush, and keeps saturating hazard/flush event counters.

Parameters:
CTRL_W, 16, width of the opaque execute-control bundle carried through.
CNT_W, 32, width of each saturating event counter.

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
id_valid  input  1  Decode holds a valid instruction
id_pc  input  32  PC of Decode instruction
id_rs1, id_rs2  input  5 each  source register indices
id_rd  input  5  destination register index
id_rd1, id_rd2  input  32 each  register-file read data for rs1/rs2
id_uses_rs1, id_uses_rs2  input  1 each  instruction actually reads rs1/rs2
id_imm  input  32  sign-extended immediate
id_ctrl  input  CTRL_W  execute control bundle
id_reg_we  input  1  instruction writes rd
id_mem_read  input  1  instruction is a load
wb_we  input  1  write-back stage writing the register file this cycle
wb_wa  input  5  write-back address
wb_wd  input  32  write-back data
ex_ready  input  1  Execute can accept a new instruction
flush  input  1  branch/jump redirect; squash Decode instruction
id_stall  output  1  hold PC and IF/ID register (combinational)
ex_valid  output  1  Execute slot holds a valid instruction
ex_pc, ex_imm  output  32 each  registered PC / immediate
ex_rs1, ex_rs2, ex_rd  output  5 each  registered indices for forwarding unit
ex_op1, ex_op2  output  32 each  registered operands after bypass
ex_ctrl  output  CTRL_W  registered control
ex_reg_we, ex_mem_read  output  1 each  registered, gated by validity
hazard_cnt, flush_cnt  output  CNT_W each  saturating event counters

Behaviour:
- Reset: every registered output is 0 on the edge where rst=1. id_stall is forced 0 while rst=1.
- Latency: 1 cycle from Decode to ex_* outputs.
- Bypass, combinational, per operand:
  - op1_n = 0 if id_rs1==0;
  - else wb_wd if wb_we && wb_wa!=0 && wb_wa==id_rs1;
  - else id_rd1.
  - op2_n is identical using rs2/rd2.
- hold = ex_valid && !ex_ready.
- hazard = id_valid && ex_valid && ex_mem_read && ex_rd!=0 && ((id_uses_rs1 && id_rs1==ex_rd) || (id_uses_rs2 && id_rs2==ex_rd)).
- id_stall = !rst && !flush && (hold || hazard).
- Register update priority, evaluated each edge:
  1. rst: clear all.
  2. flush: ex_valid, ex_reg_we, ex_mem_read, ex_ctrl <= 0; flush_cnt += 1. Flush overrides hold.
  3. hold: all ex_* keep their values; counters unchanged.
  4. hazard: bubble. ex_valid, ex_reg_we, ex_mem_read, ex_ctrl <= 0; hazard_cnt += 1. The Decode instruction stays in Decode (id_stall=1) and is re-evaluated next cycle with fresh bypass.
  5. else load: ex_valid <= id_valid. All fields load from id_*/op*_n. ex_reg_we <= id_reg_we && id_valid; ex_mem_read <= id_mem_read && id_valid; ex_ctrl <= id_valid ? id_ctrl : 0.
- Bubble/flush cycles: ex_pc, ex_imm, ex_rs*, ex_rd, ex_op* keep their previous values (don't-care, but stable).
- Counters saturate at 2^CNT_W-1 and never wrap.
- flush in the same cycle as hazard: only flush_cnt increments.
- Hazard while hold: no bubble and no count; the hazard is re-evaluated once hold clears.
- Loads are never produced with rd=x0 hazards: ex_rd==0 never stalls.

Test Plan:
1. Reset: rst=1 for 2 cycles with id_valid=1 -> ex_valid=0, ex_reg_we=0, ex_mem_read=0, both counters=0, id_stall=0.
2. Pass-through: id_valid=1, rs1=5/id_rd1=0x11, rs2=6/id_rd2=0x22, imm=0xFFFF_FFF0, wb_we=0 -> next cycle ex_valid=1, ex_op1=0x11, ex_op2=0x22, ex_imm=0xFFFF_FFF0.
3. Bypass boundaries, each checked in ex_op1 next cycle:
   - rs1=7, id_rd1=0xAAAA, wb_we=1, wb_wa=7, wb_wd=0x1234 -> 0x1234.
   - rs1=0, wb_wa=0, wb_wd=0x55 -> 0.
   - wb_we=0, same address -> 0xAAAA.
4. Load-use: EX holds load rd=3; Decode add rs1=3 with uses_rs1=1 -> id_stall=1 for exactly one cycle, ex_valid=0 next cycle, hazard_cnt=1, then the add loads with ex_valid=1. Repeat with uses_rs1=0 -> no stall.
5. Back-pressure: ex_ready=0 for 3 cycles with new id_* each cycle -> ex_* unchanged, id_stall=1 throughout; ex_ready=1 -> the current Decode instruction loads.
6. Flush and saturation:
   - flush=1 together with a hazard -> ex_valid=0, flush_cnt=1, hazard_cnt unchanged, id_stall=0.
   - CNT_W=4 with 20 hazards -> hazard_cnt holds at 15.
